// File: rtl/duty_ramp_pkg.sv
// Shared types, constants and arithmetic helpers for the duty_ramp slice.
package duty_ramp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAMP    = 2'd1,
        REVERSE = 2'd2,
        DEAD    = 2'd3
    } ramp_state_t;

    localparam int              DUTY_W   = 11;
    localparam logic [DUTY_W-1:0] DUTY_MAX = 11'h7FF;

    // Magnitude of a signed 12-bit command; -2048 has no positive twin and
    // saturates to the largest duty.
    function automatic logic [DUTY_W-1:0] cmd_mag(input logic [DUTY_W:0] c);
        logic [DUTY_W-1:0] m;
        if (!c[DUTY_W]) begin
            m = c[DUTY_W-1:0];
        end else if (c[DUTY_W-1:0] == '0) begin
            m = DUTY_MAX;
        end else begin
            m = ~c[DUTY_W-1:0] + 11'd1;
        end
        return m;
    endfunction

    // One slew-limited step of duty toward tgt. Sums are formed one bit wider
    // than the duty so that duty + step can never wrap past 2047.
    function automatic logic [DUTY_W-1:0] step_toward(
        input logic [DUTY_W-1:0] duty,
        input logic [DUTY_W-1:0] tgt,
        input logic [DUTY_W:0]   step
    );
        logic [DUTY_W:0]   d;
        logic [DUTY_W:0]   t;
        logic [DUTY_W:0]   sum;
        logic [DUTY_W-1:0] r;
        d   = {1'b0, duty};
        t   = {1'b0, tgt};
        sum = d + step;
        if (d < t) begin
            r = (sum > t) ? tgt : sum[DUTY_W-1:0];
        end else if (d < t + step) begin
            r = tgt;
        end else begin
            r = duty - step[DUTY_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/duty_ramp_period_tick.sv
// Free-running PWM period counter; tick marks the last clock of each period
// so that registers updated on tick take effect from PWM count 0.
module duty_ramp_period_tick #(
    parameter int PER_BITS = 11
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    logic [PER_BITS-1:0] cnt_q;
    logic [PER_BITS-1:0] cnt_d;

    // Next count and end-of-period flag.
    always_comb begin
        cnt_d = cnt_q + PER_BITS'(1);
        tick  = &cnt_q;
    end

    // Counter register, cleared together with the PWM counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/duty_ramp.sv
// Slew-rate limited duty generator for the 11-bit PWM stage.
// Optional feature macro: DUTY_RAMP_DEADTIME_EN inserts one zero-duty period
// (DEAD state) between the ramp-down and the ramp-up of a direction reversal.
//
// Handshake: a command transfers in any cycle where cmd_vld and cmd_rdy are
// both high at the rising clock edge. cmd_rdy depends only on the state
// (high in IDLE and RAMP), never on cmd_vld; the source holds cmd stable
// while cmd_vld is high and cmd_rdy is low.
module duty_ramp
    import duty_ramp_pkg::*;
#(
    parameter int STEP     = 16,
    parameter int PER_BITS = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DUTY_W:0]   cmd,
    input  logic              cmd_vld,
    output logic              cmd_rdy,
    output logic [DUTY_W-1:0] duty,
    output logic              fwd,
    output logic              at_target,
    output ramp_state_t       dbg_state
);

    localparam logic [DUTY_W:0] STEP_C = 12'(STEP);

    ramp_state_t       state_q, state_d, eff_state;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              fwd_q, fwd_d;
    logic [DUTY_W-1:0] tmag_q, tmag_d;
    logic              tdir_q, tdir_d;
    logic              at_target_q, at_target_d;

    logic              tick;
    logic              accept;
    logic [DUTY_W-1:0] new_mag;
    logic              new_dir;
    logic [DUTY_W-1:0] ramp_step;
    logic [DUTY_W-1:0] rev_step;

    duty_ramp_period_tick #(
        .PER_BITS(PER_BITS)
    ) u_period_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    assign cmd_rdy   = (state_q == IDLE) || (state_q == RAMP);
    assign accept    = cmd_vld && cmd_rdy;
    assign new_mag   = cmd_mag(cmd);
    assign new_dir   = ~cmd[DUTY_W];

    assign duty      = duty_q;
    assign fwd       = fwd_q;
    assign at_target = at_target_q;
    assign dbg_state = state_q;

    // Target capture, accept-time state decision, then the per-period step.
    always_comb begin
        state_d   = state_q;
        eff_state = state_q;
        duty_d    = duty_q;
        fwd_d     = fwd_q;
        tmag_d    = tmag_q;
        tdir_d    = tdir_q;

        // An accept decides the state immediately so that a tick in the same
        // cycle already steps toward the new target. A zero target never
        // counts as a direction change: there is nothing to reverse into.
        if (accept) begin
            tmag_d = new_mag;
            tdir_d = new_dir;
            if ((new_mag == duty_q) && ((new_dir == fwd_q) || (new_mag == '0))) begin
                eff_state = IDLE;
            end else if ((new_dir != fwd_q) && (new_mag != '0) && (duty_q != '0)) begin
                eff_state = REVERSE;
            end else begin
                eff_state = RAMP;
            end
        end
        state_d = eff_state;

        ramp_step = step_toward(duty_q, tmag_d, STEP_C);
        rev_step  = step_toward(duty_q, '0, STEP_C);

        if (tick) begin
            case (eff_state)
                RAMP: begin
                    duty_d = ramp_step;
                    // Only reached with duty == 0 or matching direction, so
                    // flipping fwd here never happens under nonzero duty.
                    if (tmag_d != '0) begin
                        fwd_d = tdir_d;
                    end
                    if (ramp_step == tmag_d) begin
                        state_d = IDLE;
                    end
                end
                REVERSE: begin
                    duty_d = rev_step;
                    if (rev_step == '0) begin
                        fwd_d = tdir_d;
`ifdef DUTY_RAMP_DEADTIME_EN
                        state_d = DEAD;
`else
                        state_d = RAMP;
`endif
                    end
                end
`ifdef DUTY_RAMP_DEADTIME_EN
                DEAD: begin
                    // Duty held at zero for this whole period; ramp-up starts
                    // on the following tick.
                    state_d = RAMP;
                end
`endif
                default: begin
                end
            endcase
        end

        at_target_d = (state_d == IDLE) && (duty_d == tmag_d) &&
                      ((fwd_d == tdir_d) || (tmag_d == '0));
    end

    // State and output registers; reset drops duty at once, no ramp-down.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            duty_q      <= '0;
            fwd_q       <= 1'b1;
            tmag_q      <= '0;
            tdir_q      <= 1'b1;
            at_target_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            duty_q      <= duty_d;
            fwd_q       <= fwd_d;
            tmag_q      <= tmag_d;
            tdir_q      <= tdir_d;
            at_target_q <= at_target_d;
        end
    end

endmodule

// File: tb/tb_duty_ramp.sv
// Directed bench for duty_ramp: a default instance (2048-clk period) and a
// short-period instance (16 clk) used for the long full-scale ramps.
module tb_duty_ramp;
    import duty_ramp_pkg::*;

    localparam int PER   = 2048;
    localparam int PER_F = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst_f;
    logic [11:0] cmd;
    logic [11:0] cmd_f;
    logic        cmd_vld;
    logic        cmd_vld_f;
    logic        cmd_rdy, cmd_rdy_f;
    logic [10:0] duty, duty_f;
    logic        fwd, fwd_f;
    logic        at_target, at_target_f;
    ramp_state_t dbg_state, dbg_state_f;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int cyc_f = 0;

    duty_ramp u_dut (
        .clk      (clk),
        .rst      (rst),
        .cmd      (cmd),
        .cmd_vld  (cmd_vld),
        .cmd_rdy  (cmd_rdy),
        .duty     (duty),
        .fwd      (fwd),
        .at_target(at_target),
        .dbg_state(dbg_state)
    );

    duty_ramp #(
        .STEP    (16),
        .PER_BITS(4)
    ) u_fast (
        .clk      (clk),
        .rst      (rst_f),
        .cmd      (cmd_f),
        .cmd_vld  (cmd_vld_f),
        .cmd_rdy  (cmd_rdy_f),
        .duty     (duty_f),
        .fwd      (fwd_f),
        .at_target(at_target_f),
        .dbg_state(dbg_state_f)
    );

    // Clock and bench-side cycle counts since reset release.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
        if (rst_f) cyc_f <= 0;
        else       cyc_f <= cyc_f + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Return #1 after the next period-boundary edge.
    task automatic tick_main();
        do begin
            @(posedge clk);
            #1;
        end while ((cyc % PER) != 0);
    endtask

    task automatic tick_fast();
        do begin
            @(posedge clk);
            #1;
        end while ((cyc_f % PER_F) != 0);
    endtask

    task automatic send(input logic [11:0] v);
        cmd     = v;
        cmd_vld = 1'b1;
        @(posedge clk);
        #1;
        cmd_vld = 1'b0;
    endtask

    task automatic send_f(input logic [11:0] v);
        cmd_f     = v;
        cmd_vld_f = 1'b1;
        @(posedge clk);
        #1;
        cmd_vld_f = 1'b0;
    endtask

    initial begin
        int e1 [7];
        int e2 [7];
        int f2 [7];
        int e3 [3];
        int exp_d;

        e1 = '{16, 32, 48, 64, 80, 96, 100};
        e2 = '{84, 68, 52, 36, 20, 4, 0};
        f2 = '{1, 1, 1, 1, 1, 1, 0};
        e3 = '{16, 32, 40};

        rst = 1'b1;  rst_f = 1'b1;
        cmd = '0;    cmd_f = '0;
        cmd_vld = 1'b0; cmd_vld_f = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_duty",      duty, 0);
        check("rst_fwd",       fwd, 1);
        check("rst_at_target", at_target, 1);
        check("rst_cmd_rdy",   cmd_rdy, 1);
        check("rst_state",     dbg_state, IDLE);

        // ---- short-period instance: mid-ramp reset, full-scale ramp ----
        #3 rst_f = 1'b0;
        @(posedge clk);
        #1;
        send_f(12'hC18);                          // -1000
        for (int k = 1; k <= 31; k++) begin
            tick_fast();
            check("f_neg_ramp", duty_f, 16 * k);
        end
        check("f_neg_fwd", fwd_f, 0);
        #3 rst_f = 1'b1;
        #1;
        check("f_rst_duty",      duty_f, 0);
        check("f_rst_fwd",       fwd_f, 1);
        check("f_rst_cmd_rdy",   cmd_rdy_f, 1);
        check("f_rst_at_target", at_target_f, 1);
        repeat (3) @(posedge clk);
        #3 rst_f = 1'b0;
        @(posedge clk);
        #1;
        send_f(12'h800);                          // -2048
        for (int k = 1; k <= 128; k++) begin
            tick_fast();
            exp_d = (16 * k > 2047) ? 2047 : 16 * k;
            check("f_full_ramp", duty_f, exp_d);
        end
        tick_fast();
        check("f_full_hold",      duty_f, 2047);
        check("f_full_fwd",       fwd_f, 0);
        check("f_full_at_target", at_target_f, 1);

        // ---- default instance: accept in the tick cycle ----
        #3 rst = 1'b0;
        do begin
            @(posedge clk);
            #1;
        end while (cyc != PER - 1);
        check("pre_tick_duty", duty, 0);
        send(12'd50);
        check("tick_accept_duty",      duty, 16);
        check("tick_accept_at_target", at_target, 0);
        tick_main();
        check("tick_accept_duty2", duty, 32);

        // asynchronous reset mid-ramp
        #3 rst = 1'b1;
        #1;
        check("mid_rst_duty",      duty, 0);
        check("mid_rst_fwd",       fwd, 1);
        check("mid_rst_cmd_rdy",   cmd_rdy, 1);
        check("mid_rst_at_target", at_target, 1);
        check("mid_rst_state",     dbg_state, IDLE);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;

        // ---- ramp up to +100 ----
        repeat (2) @(posedge clk);
        #1;
        send(12'd100);
        check("up_at_target_drop", at_target, 0);
        check("up_cmd_rdy",        cmd_rdy, 1);
        for (int k = 0; k < 7; k++) begin
            tick_main();
            check("up_ramp", duty, e1[k]);
        end
        check("up_at_target", at_target, 1);
        check("up_state",     dbg_state, IDLE);

        // ---- reversal to -40 ----
        repeat (3) @(posedge clk);
        #1;
        send(12'hFD8);                            // -40
        check("rev_cmd_rdy",   cmd_rdy, 0);
        check("rev_at_target", at_target, 0);
        for (int k = 0; k < 7; k++) begin
            tick_main();
            check("rev_down", duty, e2[k]);
            check("rev_fwd",  fwd, f2[k]);
            if (k < 6) check("rev_rdy_low", cmd_rdy, 0);
        end
`ifdef DUTY_RAMP_DEADTIME_EN
        check("rev_dead_rdy", cmd_rdy, 0);
        tick_main();
        check("rev_dead_duty", duty, 0);
`endif
        check("rev_ramp_rdy", cmd_rdy, 1);
        for (int k = 0; k < 3; k++) begin
            tick_main();
            check("rev_up", duty, e3[k]);
            check("rev_up_fwd", fwd, 0);
        end
        check("rev_at_target", at_target, 1);

        // ---- held command while not ready ----
        repeat (3) @(posedge clk);
        #1;
        send(12'd20);
        cmd     = 12'd30;
        cmd_vld = 1'b1;
        tick_main();
        check("hold_d24",  duty, 24);
        check("hold_rdy1", cmd_rdy, 0);
        tick_main();
        check("hold_d8",   duty, 8);
        check("hold_rdy2", cmd_rdy, 0);
        tick_main();
        check("hold_d0",   duty, 0);
        check("hold_fwd",  fwd, 1);
`ifdef DUTY_RAMP_DEADTIME_EN
        check("hold_dead_rdy", cmd_rdy, 0);
        tick_main();
        check("hold_dead_duty", duty, 0);
`endif
        check("hold_rdy_back", cmd_rdy, 1);
        @(posedge clk);
        #1;
        cmd_vld = 1'b0;
        tick_main();
        check("hold_up16", duty, 16);
        tick_main();
        check("hold_up30", duty, 30);
        check("hold_at_target", at_target, 1);

        // ---- command equal to the present state ----
        repeat (3) @(posedge clk);
        #1;
        send(12'd30);
        check("same_at_target", at_target, 1);
        check("same_state",     dbg_state, IDLE);
        tick_main();
        check("same_duty",       duty, 30);
        check("same_at_target2", at_target, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
